ifetch_unit: RTL and testbench

Instruction-fetch initiator that drives the synchronous-read instruction memory. The memory has 1-cycle read latency and is byte-addressed, little-endian, with a 32-bit word.
- Generates the PC and tracks which PC each returning word belongs to.
- Absorbs decode back-pressure with a one-entry hold buffer.
- Handles redirects from EX.
- Delivers {instr, pc, valid} to the IF/ID register at one instruction per cycle when unstalled.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid.sv | 83 ++++++++
 rtl/ifetch_unit.sv | 80 ++++++++
 tb/tb_ifetch_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and the IF/ID register.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FS_RUN,
        FS_HOLD
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            valid;
    } fetch_pkt_t;

    // Clear the byte-offset bits so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry hold buffer with RUN/HOLD FSM. Captures the word on the memory bus when
// decode stalls, presents it until accepted, and masks the output during redirects.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] rsp_instr_i,
    input  logic [31:0] rsp_pc_i,
    input  logic        rsp_vld_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    fetch_pkt_t      pkt;

    // FSM and hold register next state; redirect discards any held entry.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        hold_pc_d = hold_pc_q;
        if (redirect_i) begin
            state_d   = FS_RUN;
            hold_d    = '0;
            hold_pc_d = '0;
        end else begin
            unique case (state_q)
                FS_RUN: begin
                    // Bubbles are never buffered: only a valid word is worth holding.
                    if (stall_i && rsp_vld_i) begin
                        hold_d    = rsp_instr_i;
                        hold_pc_d = rsp_pc_i;
                        state_d   = FS_HOLD;
                    end
                end
                FS_HOLD: begin
                    if (!stall_i) begin
                        state_d = FS_RUN;
                    end
                end
                default: state_d = FS_RUN;
            endcase
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FS_RUN;
            hold_q    <= '0;
            hold_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            hold_pc_q <= hold_pc_d;
        end
    end

    // Output mux: live memory response in RUN, held entry in HOLD; NOP whenever invalid.
    always_comb begin
        pkt.instr = rsp_instr_i;
        pkt.pc    = rsp_pc_i;
        pkt.valid = rsp_vld_i;
        if (state_q == FS_HOLD) begin
            pkt.instr = hold_q;
            pkt.pc    = hold_pc_q;
            pkt.valid = 1'b1;
        end
        if (redirect_i) begin
            pkt.valid = 1'b0;
        end
        valid_o = pkt.valid;
        instr_o = pkt.valid ? pkt.instr : INSTR_NOP;
        pc_o    = pkt.pc;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch initiator: generates the PC for a 1-cycle synchronous-read memory,
// tracks which PC the returning word belongs to, and hands words to decode via a skid.
module ifetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 16384
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output logic        fetch_err_o
);

    // Highest PC whose full word lies inside the instruction memory.
    localparam logic [XLEN-1:0] ERR_LIMIT = XLEN'(IMEM_BYTES - 32'd4);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic            rsp_vld_q, rsp_vld_d;

    // PC generation. Under stall the address is held in both FSM states, so the memory
    // keeps re-reading pc_q and the word for pc_q is on the bus when the stall lifts.
    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        rsp_vld_d = rsp_vld_q;
        if (redirect_i) begin
            pc_d      = align_pc(redirect_pc_i);
            rsp_vld_d = 1'b0;
        end else if (!stall_i) begin
            rsp_pc_d  = pc_q;
            rsp_vld_d = 1'b1;
            pc_d      = pc_q + PC_STEP;
        end
    end

    // PC and response-tracking registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q      <= align_pc(RESET_PC);
            rsp_pc_q  <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign imem_addr_o = pc_q;

    fetch_skid u_skid (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .stall_i     (stall_i),
        .redirect_i  (redirect_i),
        .rsp_instr_i (imem_data_i),
        .rsp_pc_i    (rsp_pc_q),
        .rsp_vld_i   (rsp_vld_q),
        .valid_o     (valid_o),
        .instr_o     (instr_o),
        .pc_o        (pc_o)
    );

    // Link value and out-of-range flag derived from the delivered PC.
    always_comb begin
        pc_plus4_o  = pc_o + PC_STEP;
        fetch_err_o = valid_o && (pc_o > ERR_LIMIT);
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: stimulus pushes expected deliveries, a negedge
// monitor compares each accepted (valid && !stall) output against the queue head.
module tb_ifetch_unit;

    logic        clk;
    logic        rst_ni;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   failures;

    ifetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (16384)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .valid_o       (valid),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .fetch_err_o   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory; each word is tagged with its own address.
    always @(posedge clk) imem_data <= 32'hA5A5_0000 ^ imem_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [31:0] w, input logic e);
        exp_t x;
        x.pc = p;
        x.instr = w;
        x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bubble(input string name);
        @(negedge clk);
        check(name, {31'd0, valid}, 32'd0);
    endtask

    // Monitor: pops on acceptance, peeks for stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (redirect) begin
                    check("redirect_valid", {31'd0, valid}, 32'd0);
                end else if (!valid) begin
                    check("idle_nop", instr, 32'h0000_0013);
                    check("idle_err", {31'd0, fetch_err}, 32'd0);
                end else if (exp_q.size() == 0) begin
                    if (!stall) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_delivery actual_pc=%h required=none", pc);
                    end
                end else begin
                    e = exp_q[0];
                    check(stall ? "stall_pc" : "pc", pc, e.pc);
                    check(stall ? "stall_instr" : "instr", instr, e.instr);
                    check("pc_plus4", pc_plus4, e.pc + 32'd4);
                    check("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                    if (!stall) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rst_ni = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, 32'h0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);

        // Sequential fetch, then a 3-cycle stall on 0x8.
        push(32'h0, 32'hA5A5_0000, 1'b0);
        push(32'h4, 32'hA5A5_0004, 1'b0);
        push(32'h8, 32'hA5A5_0008, 1'b0);
        push(32'hC, 32'hA5A5_000C, 1'b0);
        push(32'h10, 32'hA5A5_0010, 1'b0);
        step();
        rst_ni = 1'b1;
        expect_bubble("bubble_after_reset");
        step();               // pc 0x0
        step();               // pc 0x4
        step();               // pc 0x8
        stall = 1'b1;
        step();
        step();
        step();
        stall = 1'b0;         // held 0x8 accepted
        step();               // pc 0xC
        step();               // pc 0x10, stalled
        stall = 1'b1;
        step();               // 0x10 held; redirect overrides the stall
        check("queue_before_redirect", exp_q.size(), 32'd1);
        exp_q.delete();
        push(32'h100, 32'hA5A5_0100, 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        stall = 1'b0;
        expect_bubble("redirect_bubble");
        step();               // pc 0x100

        // Back-to-back redirects: 0x40 must never be delivered.
        step();               // 0x104 on the bus, flushed
        push(32'h80, 32'hA5A5_0080, 1'b0);
        push(32'h84, 32'hA5A5_0084, 1'b0);
        redirect = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h80;
        step();
        redirect = 1'b0;
        expect_bubble("b2b_bubble");
        step();               // pc 0x80
        step();               // pc 0x84

        // Memory-end boundary.
        step();               // 0x88 on the bus, flushed
        check("queue_before_boundary", exp_q.size(), 32'd0);
        push(32'h3FFC, 32'hA5A5_3FFC, 1'b0);
        push(32'h4000, 32'hA5A5_4000, 1'b1);
        push(32'h4004, 32'hA5A5_4004, 1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h3FFC;
        step();
        redirect = 1'b0;
        expect_bubble("boundary_bubble");
        step();               // 0x3FFC
        step();               // 0x4000
        step();               // 0x4004, stalled
        stall = 1'b1;
        step();               // now in hold

        // Asynchronous reset while holding.
        #2;
        check("hold_valid", {31'd0, valid}, 32'd1);
        check("hold_pc", pc, 32'h4004);
        rst_ni = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, valid}, 32'd0);
        check("async_rst_instr", instr, 32'h0000_0013);
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_err", {31'd0, fetch_err}, 32'd0);
        check("async_rst_addr", imem_addr, 32'h0);
        check("queue_before_reset", exp_q.size(), 32'd1);
        exp_q.delete();
        stall = 1'b0;
        push(32'h0, 32'hA5A5_0000, 1'b0);
        push(32'h4, 32'hA5A5_0004, 1'b0);
        push(32'h8, 32'hA5A5_0008, 1'b0);
        step();
        rst_ni = 1'b1;
        expect_bubble("bubble_after_rerun");
        step();               // 0x0
        step();               // 0x4
        step();               // 0x8
        step();               // 0xC on the bus, parked
        stall = 1'b1;
        check("queue_drained", exp_q.size(), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
